// File: rtl/sec_min_timer_ctrl_if.sv
// Command and status bundle between the push-button decoder and the seconds/minutes timer controller.
interface sec_min_timer_ctrl_if;
    // Commands are plain levels sampled on every clk edge; no valid/ready handshake is involved.
    logic       start;
    logic       pause;
    logic       clear;
    logic       alarm_en;
    logic [5:0] alarm_min;
    logic [5:0] alarm_sec;
    logic [5:0] sec;
    logic [5:0] min;
    logic       tick;
    logic       wrap;
    logic       alarm;
    logic       running;
    logic [1:0] state;

    modport master (
        output start, pause, clear, alarm_en, alarm_min, alarm_sec,
        input  sec, min, tick, wrap, alarm, running, state
    );

    modport slave (
        input  start, pause, clear, alarm_en, alarm_min, alarm_sec,
        output sec, min, tick, wrap, alarm, running, state
    );
endinterface

// File: rtl/sec_min_timer_ctrl.sv
// Run/pause/clear controller for a cascaded seconds/minutes timer with alarm match and wrap flag.
module sec_min_timer_ctrl #(
    parameter int TICK_DIV = 6,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59
) (
    input  logic                 clk,
    input  logic                 rst,
    sec_min_timer_ctrl_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic          tick_q, tick_d, wrap_q, wrap_d, alarm_q, alarm_d;
    logic [5:0]    sec_adv, min_adv;
    logic          wrap_adv, presc_last, alarm_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            alarm_q <= alarm_d;
        end
    end

    // Post-advance time; the alarm compares against this, not the current value.
    always_comb begin
        sec_adv  = sec_q + 6'd1;
        min_adv  = min_q;
        wrap_adv = 1'b0;
        if (sec_q == 6'(SEC_MAX)) begin
            sec_adv = 6'd0;
            if (min_q == 6'(MIN_MAX)) begin
                min_adv  = 6'd0;
                wrap_adv = 1'b1;
            end else begin
                min_adv = min_q + 6'd1;
            end
        end
        presc_last = (presc_q == PW'(TICK_DIV - 1));
        alarm_hit  = bus.alarm_en && (sec_adv == bus.alarm_sec) && (min_adv == bus.alarm_min);
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        alarm_d = alarm_q;
        if (bus.clear) begin
            state_d = IDLE;
            presc_d = '0;
            sec_d   = '0;
            min_d   = '0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    // start outranks pause, and start in RUN just keeps counting.
                    if (bus.pause && !bus.start) begin
                        state_d = PAUSE;
                    end else if (presc_last) begin
                        presc_d = '0;
                        sec_d   = sec_adv;
                        min_d   = min_adv;
                        tick_d  = 1'b1;
                        wrap_d  = wrap_adv;
                        if (alarm_hit) begin
                            state_d = DONE;
                            alarm_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.start) state_d = RUN;
                end
                DONE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        presc_d = '0;
                        alarm_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.sec     = sec_q;
    assign bus.min     = min_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.alarm   = alarm_q;
    assign bus.state   = state_q;
    assign bus.running = (state_q == RUN);
endmodule

// File: tb/tb_sec_min_timer_ctrl.sv
// Randomized and directed bench for sec_min_timer_ctrl, two parameter sets checked against a total-seconds model.
module tb_sec_min_timer_ctrl;
    localparam int DIV_A = 6, SMAX_A = 59, MMAX_A = 59;
    localparam int DIV_B = 4, SMAX_B = 2,  MMAX_B = 1;

    logic clk;
    logic rst;
    logic start, pause, clear, alarm_en;
    logic [5:0] alarm_min, alarm_sec;

    sec_min_timer_ctrl_if if_a ();
    sec_min_timer_ctrl_if if_b ();

    assign if_a.start = start;  assign if_b.start = start;
    assign if_a.pause = pause;  assign if_b.pause = pause;
    assign if_a.clear = clear;  assign if_b.clear = clear;
    assign if_a.alarm_en  = alarm_en;   assign if_b.alarm_en  = alarm_en;
    assign if_a.alarm_min = alarm_min;  assign if_b.alarm_min = alarm_min;
    assign if_a.alarm_sec = alarm_sec;  assign if_b.alarm_sec = alarm_sec;

    sec_min_timer_ctrl #(.TICK_DIV(DIV_A), .SEC_MAX(SMAX_A), .MIN_MAX(MMAX_A)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    sec_min_timer_ctrl #(.TICK_DIV(DIV_B), .SEC_MAX(SMAX_B), .MIN_MAX(MMAX_B)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed word: {state, running, alarm, wrap, tick, min, sec}
    logic [17:0] obs_a, obs_b;
    assign obs_a = {if_a.state, if_a.running, if_a.alarm, if_a.wrap, if_a.tick, if_a.min, if_a.sec};
    assign obs_b = {if_b.state, if_b.running, if_b.alarm, if_b.wrap, if_b.tick, if_b.min, if_b.sec};

    // reference model: time kept as total elapsed seconds
    int p_div[2]  = '{DIV_A, DIV_B};
    int p_smax[2] = '{SMAX_A, SMAX_B};
    int p_mmax[2] = '{MMAX_A, MMAX_B};
    int m_state[2];
    int m_presc[2];
    int m_total[2];
    int m_tick[2];
    int m_wrap[2];
    int m_alarm[2];

    logic [17:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    string phase = "reset";

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s_%s: got %h expected %h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_state[i] = 0; m_presc[i] = 0; m_total[i] = 0;
        m_tick[i] = 0;  m_wrap[i] = 0;  m_alarm[i] = 0;
    endtask

    task automatic model_step(input int i);
        int s, m;
        m_tick[i] = 0;
        m_wrap[i] = 0;
        if (!rst) begin
            model_reset(i);
        end else if (clear) begin
            m_state[i] = 0; m_presc[i] = 0; m_total[i] = 0; m_alarm[i] = 0;
        end else if (m_state[i] == 0) begin
            if (start) begin m_state[i] = 1; m_presc[i] = 0; end
        end else if (m_state[i] == 1) begin
            if (pause && !start) begin
                m_state[i] = 2;
            end else if (m_presc[i] == p_div[i] - 1) begin
                m_presc[i] = 0;
                m_total[i] = (m_total[i] + 1) % ((p_mmax[i] + 1) * (p_smax[i] + 1));
                m_tick[i] = 1;
                m_wrap[i] = (m_total[i] == 0) ? 1 : 0;
                s = m_total[i] % (p_smax[i] + 1);
                m = m_total[i] / (p_smax[i] + 1);
                if (alarm_en && s == int'(alarm_sec) && m == int'(alarm_min)) begin
                    m_state[i] = 3;
                    m_alarm[i] = 1;
                end
            end else begin
                m_presc[i]++;
            end
        end else if (m_state[i] == 2) begin
            if (start) m_state[i] = 1;
        end else begin
            if (start) begin m_state[i] = 1; m_presc[i] = 0; m_alarm[i] = 0; end
        end
    endtask

    function automatic logic [17:0] exp_vec(input int i);
        logic [1:0] st;
        logic [5:0] s, m;
        st = 2'(m_state[i]);
        s  = 6'(m_total[i] % (p_smax[i] + 1));
        m  = 6'(m_total[i] / (p_smax[i] + 1));
        return {st, (m_state[i] == 1), (m_alarm[i] != 0), (m_wrap[i] != 0), (m_tick[i] != 0), m, s};
    endfunction

    // driver: one clock edge with the current inputs, then score both DUTs
    task automatic step_cycle();
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            exp_q.push_back(exp_vec(i));
        end
        @(posedge clk);
        @(negedge clk);
        check("a", obs_a, exp_q.pop_front());
        check("b", obs_b, exp_q.pop_front());
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) step_cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step_cycle();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step_cycle();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0; pause = 1'b0; clear = 1'b0;
        alarm_en = 1'b0; alarm_min = 6'd0; alarm_sec = 6'd0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        check("a", obs_a, exp_vec(0));
        check("b", obs_b, exp_vec(1));
        run_cycles(2);
        rst = 1'b1;
        run_cycles(2);

        phase = "count";
        pulse_start();
        run_cycles(360);
        check("a_60ticks", 18'({if_a.min, if_a.sec}), 18'({6'd1, 6'd0}));

        phase = "alarm";
        do_clear();
        alarm_en = 1'b1; alarm_min = 6'd0; alarm_sec = 6'd3;
        pulse_start();
        run_cycles(18);
        check("a_done", 18'({if_a.state, if_a.alarm, if_a.sec}), 18'({2'd3, 1'b1, 6'd3}));
        run_cycles(20);
        check("a_hold", 18'(if_a.sec), 18'd3);
        pulse_start();
        alarm_en = 1'b0;
        run_cycles(6);
        check("a_resume", 18'({if_a.state, if_a.alarm, if_a.sec}), 18'({2'd1, 1'b0, 6'd4}));

        phase = "pause";
        do_clear();
        pulse_start();
        run_cycles(3);
        pause = 1'b1;
        run_cycles(10);
        pause = 1'b0;
        pulse_start();
        run_cycles(3);
        check("a_pause_tick", 18'({if_a.tick, if_a.sec}), 18'({1'b1, 6'd1}));

        phase = "prio";
        do_clear();
        pulse_start();
        run_cycles(5);
        pause = 1'b1;
        step_cycle();
        start = 1'b1;
        step_cycle();
        start = 1'b0; pause = 1'b0;
        run_cycles(3);
        clear = 1'b1; start = 1'b1;
        step_cycle();
        clear = 1'b0; start = 1'b0;

        phase = "async";
        pulse_start();
        run_cycles(42);
        #2 rst = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check("a_now", obs_a, exp_vec(0));
        check("b_now", obs_b, exp_vec(1));
        @(negedge clk);
        run_cycles(3);
        rst = 1'b1;
        run_cycles(10);

        phase = "random";
        for (int k = 0; k < 4000; k++) begin
            clear = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 99) < 8);
            pause = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 49) == 0) begin
                alarm_en  = 1'($urandom_range(0, 1));
                alarm_min = 6'($urandom_range(0, 1));
                alarm_sec = 6'($urandom_range(0, 4));
            end
            step_cycle();
        end

        phase = "end";
        check("queue_empty", 18'(exp_q.size()), 18'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sec_min_timer_ctrl.md
Name: sec_min_timer_ctrl

Overview:
- Run/pause/clear controller for a cascaded seconds/minutes timer driven by an internal divide-by-TICK_DIV prescaler.
- Owns the FSM that gates the prescaler, sequences the seconds→minutes carry, detects the alarm match and flags the full-scale wrap.
- Sits between the push-button command decoder and the display/alarm logic of the timer subsystem.

Parameters:
- TICK_DIV, 6, clk cycles per timer tick; legal values ≥2.
- SEC_MAX, 59, last seconds value before carry; legal values ≤63.
- MIN_MAX, 59, last minutes value before wrap; legal values ≤63.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level sampled each clk; enters or resumes RUN.
- pause  in  1  level sampled each clk; freezes timer.
- clear  in  1  level sampled each clk; return to IDLE at 00:00.
- alarm_en  in  1  enables alarm compare.
- alarm_min  in  6  alarm minutes value.
- alarm_sec  in  6  alarm seconds value.
- sec  out  6  current seconds, registered.
- min  out  6  current minutes, registered.
- tick  out  1  one-cycle pulse, high in the cycle sec/min first show an advanced value.
- wrap  out  1  one-cycle pulse coincident with tick when MIN_MAX:SEC_MAX → 00:00.
- alarm  out  1  sticky alarm flag.
- running  out  1  high iff state == RUN.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; prescaler=0.
  - sec=0, min=0, tick=0, wrap=0, alarm=0, running=0.
- Command priority per edge: clear > start > pause.
- clear: from any state:
  - next state IDLE; sec, min and prescaler = 0.
  - alarm=0; no tick or wrap that edge.
- IDLE: counters hold; start → RUN with prescaler=0.
- RUN:
  - prescaler increments by 1 each edge.
  - On the edge where prescaler==TICK_DIV-1: prescaler→0, sec advances, tick=1 next cycle.
  - pause (without clear/start) → PAUSE. No increment, no tick on that edge, even if prescaler==TICK_DIV-1. Prescaler value is retained.
  - start while in RUN: ignored.
- PAUSE:
  - prescaler, sec and min frozen.
  - start → RUN; counting resumes from the retained prescaler value.
  - pause: no effect.
- Advance arithmetic:
  - sec<SEC_MAX: sec+1.
  - sec==SEC_MAX: sec=0; min+1 if min<MIN_MAX, else min=0 with wrap=1.
- Alarm:
  - Compared on the tick edge against the post-advance {min,sec} when alarm_en=1.
  - On match: state→DONE, alarm=1.
  - Never matches without a tick, so alarm 00:00 fires only after a wrap, not at start.
- DONE:
  - counters and prescaler hold (prescaler=0).
  - start → RUN and alarm=0; the next tick comes TICK_DIV edges later.
  - clear → IDLE; pause ignored.
- Pulse outputs: tick and wrap are registered and high for exactly one cycle. They are 0 in every non-advance cycle.
- running and state are registered and follow the state register.
- alarm_en, alarm_min and alarm_sec are not registered; compare uses their values at the tick edge.
- Prescaler width: enough bits to hold TICK_DIV-1.

Test Plan:
1. Default params: reset, start high one cycle → first tick 6 edges after the start edge with sec=1. After 60 ticks: min=1, sec=0, tick high for exactly one cycle each time.
2. SEC_MAX=2, MIN_MAX=1: start, run 6 ticks → sequence 00:01..01:02. Sixth tick gives 00:00 with wrap=1 for one cycle; state stays RUN.
3. alarm_en=1, alarm 00:03: start → at edge 18, sec=3, state=DONE, alarm=1. Hold 20 cycles: sec stays 3, no tick. Then start → alarm=0, state=RUN, sec=4 six edges later.
4. Start, pause asserted after 3 edges, held 10 cycles (state=PAUSE, sec=0), then start → tick with sec=1 exactly 3 edges after the resume edge.
5. Pause asserted on the edge where prescaler==5 → no tick, sec unchanged, state=PAUSE. start+pause together in PAUSE → RUN. clear+start together in RUN → IDLE, sec=min=0.
6. Async reset mid-RUN at 00:07, asserted between edges → all outputs 0 and state=IDLE immediately without a clock edge. After release, counters stay 0 until start.
